// File: rtl/hex_7segment_encoder.sv
// hex_7segment_encoder: packs five active-low 7-segment digits (HEX4 first) back into the 15-bit HELLO code word.
// Optional ERR_COUNT_EN adds a saturating err_count of unrecognised digits.
module hex_7segment_encoder #(
  parameter int NUM_DIGITS = 5,
  parameter int CW         = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [6:0]               seg_in,
  input  logic                     seg_valid,
  output logic                     seg_ready,
  input  logic                     frame_sync,
  output logic [NUM_DIGITS*CW-1:0] code_word,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     word_err
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0]               err_count
`endif
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] OUTPUT  = 1'b1;

  localparam logic [6:0] SEG_H     = 7'b1001000;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_O     = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [0:0]               state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic [NUM_DIGITS*CW-1:0] word_q, word_d;
  logic                     err_acc_q, err_acc_d;
  logic [CW-1:0]            code;
  logic                     bad, acc, last;

  always_comb begin
    code = (seg_in == SEG_H) ? CW'(0) :
           (seg_in == SEG_E) ? CW'(1) :
           (seg_in == SEG_L) ? CW'(2) :
           (seg_in == SEG_O) ? CW'(3) : CW'(7);
    bad  = (code == CW'(7)) && (seg_in != SEG_BLANK);
    // a digit presented alongside frame_sync is dropped, never stored or counted
    acc  = (state_q == COLLECT) && seg_valid && !frame_sync;
    last = idx_q == 3'(NUM_DIGITS - 1);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    err_acc_d = err_acc_q;
    if (state_q == OUTPUT) begin
      state_d   = word_ready ? COLLECT : OUTPUT;
      err_acc_d = word_ready ? 1'b0 : err_acc_q;
    end else if (frame_sync) begin
      idx_d     = '0;
      err_acc_d = 1'b0;
    end else if (seg_valid) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (idx_q == 3'(i)) word_d[(NUM_DIGITS-1-i)*CW +: CW] = code;
      err_acc_d = err_acc_q | bad;
      idx_d     = last ? 3'd0 : idx_q + 3'd1;
      state_d   = last ? OUTPUT : COLLECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      word_q    <= '1;
      err_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      err_acc_q <= err_acc_d;
    end
  end

  assign seg_ready  = state_q == COLLECT;
  assign word_valid = state_q == OUTPUT;
  assign code_word  = word_q;
  assign word_err   = word_valid & err_acc_q;

`ifdef ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else if (acc && bad && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_hex_7segment_encoder.sv
// tb_hex_7segment_encoder: directed checks of the segment-to-code packer with hand-computed words.
module tb_hex_7segment_encoder;

  localparam logic [6:0] H = 7'b1001000;
  localparam logic [6:0] E = 7'b0110000;
  localparam logic [6:0] L = 7'b1110001;
  localparam logic [6:0] O = 7'b0000001;
  localparam logic [6:0] B = 7'b1111111;
  localparam logic [6:0] X = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = B;
  logic        seg_valid = 1'b0;
  logic        seg_ready;
  logic        frame_sync = 1'b0;
  logic [14:0] code_word;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic        word_err;
`ifdef ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hex_7segment_encoder dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .seg_valid(seg_valid),
    .seg_ready(seg_ready), .frame_sync(frame_sync), .code_word(code_word),
    .word_valid(word_valid), .word_ready(word_ready), .word_err(word_err)
`ifdef ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one handshake; called #1 after a rising edge and returns #1 after the accepting edge
  task automatic send(input logic [6:0] p);
    int n = 0;
    seg_in = p;
    seg_valid = 1'b1;
    while (!seg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 seg_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [14:0] cw, input logic err);
    chk({tag, "_valid"}, 32'(word_valid), 32'd1);
    chk({tag, "_word"}, 32'(code_word), 32'(cw));
    chk({tag, "_err"}, 32'(word_err), 32'(err));
    chk({tag, "_ready"}, 32'(seg_ready), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_ready"}, 32'(seg_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(seg_ready), 32'd1);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_word", 32'(code_word), 32'h7FFF);
    chk("rst_err", 32'(word_err), 32'd0);
`ifdef ERR_COUNT_EN
    chk("rst_cnt", 32'(err_count), 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    step();

    send(H); send(E); send(L); send(L); send(O);
    chk_word("hello", 15'b000_001_010_010_011, 1'b0);
    step();
    chk_idle("hello_once");

    word_ready = 1'b0;
    send(O); send(H); send(E); send(L); send(L);
    seg_in = H;
    seg_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_word("hold", 15'b011_000_001_010_010, 1'b0);
      step();
    end
    seg_valid = 1'b0;
    word_ready = 1'b1;
    step();
    chk_idle("hold_release");

    send(H); send(X); send(B); send(B); send(B);
    chk_word("bad", 15'b000_111_111_111_111, 1'b1);
`ifdef ERR_COUNT_EN
    chk("bad_cnt", 32'(err_count), 32'd1);
`endif
    step();
    send(H); send(E); send(L); send(L); send(O);
    chk_word("clean", 15'b000_001_010_010_011, 1'b0);
    step();

    send(H); send(E); send(L);
    seg_in = O;
    seg_valid = 1'b1;
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    seg_valid = 1'b0;
    chk_idle("sync");
    send(L); send(O); send(H); send(E);
    chk_idle("sync_4");
    send(L);
    chk_word("sync", 15'b010_011_000_001_010, 1'b0);
    step();
    chk_idle("sync_once");

    send(H); send(X); send(L);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ready", 32'(seg_ready), 32'd1);
    chk("mid_rst_valid", 32'(word_valid), 32'd0);
    chk("mid_rst_word", 32'(code_word), 32'h7FFF);
    chk("mid_rst_err", 32'(word_err), 32'd0);
`ifdef ERR_COUNT_EN
    chk("mid_rst_cnt", 32'(err_count), 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    step();
    send(E); send(L); send(L); send(O);
    chk_idle("after_rst_4");
    send(H);
    chk_word("after_rst", 15'b001_010_010_011_000, 1'b0);
    step();
    chk_idle("after_rst_once");

`ifdef ERR_COUNT_EN
    for (int w = 0; w < 60; w++) begin
      for (int d = 0; d < 5; d++) send(X);
      step();
    end
    chk("sat_cnt", 32'(err_count), 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_7segment_encoder.md
# hex_7segment_encoder

Reverse path of the 5-digit HELLO rotation display. Accepts active-low 7-segment patterns one digit at a time over a valid/ready handshake, leftmost digit (HEX4) first. Recovers each digit's 3-bit character code and packs the five codes into the same 15-bit layout the display decoder takes on SW[14:0]. The packed word is presented on a valid/ready output port for loopback checking and for remote-display readback.

## Interface
Parameters:
- NUM_DIGITS, 5, digits per word. The design is fixed at 5; other values are unsupported.
- CW, 3, character code width.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  segment pattern. seg_in[6]=a … seg_in[0]=g. Active-low: 0 = segment lit.
- seg_valid  in  1  seg_in carries a digit.
- seg_ready  out  1  block can accept a digit.
- frame_sync  in  1  discard any partial word and restart at digit 0 (HEX4).
- code_word  out  15  packed codes. [14:12]=HEX4, [11:9]=HEX3, [8:6]=HEX2, [5:3]=HEX1, [2:0]=HEX0.
- word_valid  out  1  code_word/word_err are valid.
- word_ready  in  1  consumer accepts the word.
- word_err  out  1  at least one digit of this word was unrecognised.
- err_count  out  8  saturating count of unrecognised digits. Present only with ERR_COUNT_EN.

## Operation
- Pattern to code mapping (seg_in, a..g):
  - 1001000 (H) -> 000
  - 0110000 (E) -> 001
  - 1110001 (L) -> 010
  - 0000001 (O) -> 011
  - 1111111 (blank) -> 111
  - any other pattern -> 111, and sets the word's error flag.
- FSM states:
  - COLLECT: holds digit index idx, 0..4.
  - OUTPUT: word is presented.
- COLLECT behaviour:
  - seg_ready=1.
  - A handshake (seg_valid & seg_ready) writes the code into slot idx. idx=0 goes to [14:12], idx=4 goes to [2:0].
  - The handshake increments idx and ORs the digit's error into err_acc.
  - The handshake that writes idx=4 moves the FSM to OUTPUT.
- OUTPUT behaviour:
  - seg_ready=0, word_valid=1.
  - code_word and word_err are stable until word_ready.
  - word_valid & word_ready returns the FSM to COLLECT with idx=0 and err_acc=0.
- frame_sync:
  - In COLLECT, it forces idx=0 and err_acc=0 on the next edge. Any handshake in the same cycle is ignored: the digit is dropped and not counted.
  - In OUTPUT, frame_sync is ignored. A presented word is never discarded.
- Slots not yet written in the current word keep their previous contents. code_word is only meaningful while word_valid=1.

## Timing
- Reset values: FSM=COLLECT, idx=0, code_word=15'h7FFF, word_valid=0, word_err=0, err_acc=0, err_count=0. seg_ready is 1 after reset.
- seg_ready is a registered-state decode with no combinational path from seg_valid. word_valid is registered.
- Latency: if the 5th digit handshakes at edge N, word_valid=1 from edge N onward, visible in cycle N+1.
- Throughput: 5 digit cycles plus 1 output cycle per word (6 cycles) when word_ready is held at 1. A new digit can be accepted in the cycle after the output handshake.
- Reset asserted mid-word or mid-OUTPUT clears everything immediately. No partial word is output.

## Configuration
- ERR_COUNT_EN:
  - Defined: err_count increments on every accepted unrecognised digit and saturates at 255. frame_sync does not clear it; only rst_n does.
  - Not defined: the err_count port and its logic are absent. word_err still works.

## Test plan
- Reset, then send H,E,L,L,O with seg_valid held high and word_ready=1. Required: word_valid for exactly 1 cycle, code_word=15'b000_001_010_010_011, word_err=0.
- Send O,H,E,L,L with word_ready=0 for 10 cycles. Required: word_valid stays 1 and code_word=15'b011_000_001_010_010 holds for the full 10 cycles; seg_ready=0 throughout. After word_ready, the next digit is accepted.
- Send H, then 0000000 (all lit), then blank,blank,blank. Required: code_word=15'b000_111_111_111_111, word_err=1. The next clean word reports word_err=0. With ERR_COUNT_EN, err_count=1.
- Send H,E,L, then pulse frame_sync with seg_valid=1 and seg_in=O, then send L,O,H,E,L. Required: one word only, 15'b010_011_000_001_010.
- Assert rst_n=0 after 3 digits. Required: all outputs return to reset values; 5 further digits produce exactly one word.
- With ERR_COUNT_EN, send 300 invalid digits (60 words). Required: err_count=255 and does not wrap.
